// File: rtl/bitop_sched_pkg.sv
// Shared types for the bit-op scheduler: word type, opcodes, FSM states.
// Pure declarations, no logic, no latency, no backpressure.
package bitop_sched_pkg;

   localparam int WIDTH = 16;

   typedef logic [WIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      OP_ONES = 2'b00,
      OP_MSB  = 2'b01,
      OP_LOG2 = 2'b10,
      OP_RSVD = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_EXEC  = 2'b01,
      S_EXEC2 = 2'b10,
      S_RESP  = 2'b11
   } state_t;

   localparam word_t LOG2_OF_ZERO = 16'hFFFF;

   function automatic word_t zext_cnt(input logic [4:0] cnt);
      return {11'b0, cnt};
   endfunction

endpackage

// File: rtl/bitop_sched_if.sv
// One requester lane: op request channel plus result response channel.
// Both channels valid/ready; master is the requester, slave the scheduler.
interface bitop_sched_if;
   import bitop_sched_pkg::*;

   logic  req_valid;
   logic  req_ready;
   op_t   req_op;
   word_t req_data;
   logic  rsp_valid;
   logic  rsp_ready;
   word_t rsp_data;

   modport master (
      output req_valid, req_op, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_op, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/bitop_sched_rr_arb.sv
// Two-way round-robin grant: a lone valid wins; on a tie the lane not served last wins,
// except right after reset when lane 0 is favoured. Combinational, no state.
module bitop_rr_arb (
   input  logic [1:0] i_valid,
   input  logic       i_rr_ptr,
   input  logic       i_fresh,
   output logic [1:0] o_grant
);
   always_comb begin
      o_grant = 2'b00;
      case (i_valid)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         2'b11:   o_grant = (i_fresh || i_rr_ptr) ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end
endmodule

// File: rtl/msb.sv
// Keeps only the highest set bit of a 16-bit word (zero in, zero out).
// Purely combinational, no backpressure.
module msb (
   input  logic [15:0] i_x,
   output logic [15:0] o_y
);
   always_comb begin
      o_y = '0;
      for (int i = 0; i < 16; i++) begin
         if (i_x[i]) o_y = 16'd1 << i;
      end
   end
endmodule

// File: rtl/ones.sv
// Population count of a 16-bit word into a 5-bit result.
// Purely combinational, no backpressure.
module ones (
   input  logic [15:0] i_x,
   output logic [4:0]  o_cnt
);
   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < 16; i++) begin
         o_cnt = o_cnt + {4'b0, i_x[i]};
      end
   end
endmodule

// File: rtl/bitop_sched.sv
// Shares one msb + one ones unit between two lanes; result valid 2 cycles after accept (LOG2: 3).
// One op in flight; request ready only in IDLE, response held until its ready.
module bitop_sched
   import bitop_sched_pkg::*;
(
   input logic          clk,
   input logic          reset,
   bitop_sched_if.slave lane0,
   bitop_sched_if.slave lane1
);

   state_t     r_state;
   state_t     w_next_state;
   logic       r_rr_ptr;
   logic       r_fresh;
   logic       r_owner;
   op_t        r_op;
   word_t      r_operand;
   word_t      r_tmp;
   word_t      r_result;

   logic [1:0] w_req_vld;
   logic [1:0] w_rsp_rdy;
   logic [1:0] w_grant;
   logic [1:0] w_req_rdy;
   logic [1:0] w_rsp_vld;
   logic       w_accept;
   logic       w_ld_tmp;
   logic       w_ld_result;
   logic       w_rsp_done;
   word_t      w_result_d;
   word_t      w_msb;
   word_t      w_ones_in;
   logic [4:0] w_ones;

   assign w_req_vld = {lane1.req_valid, lane0.req_valid};
   assign w_rsp_rdy = {lane1.rsp_ready, lane0.rsp_ready};

   bitop_rr_arb u_arb (
      .i_valid  (w_req_vld),
      .i_rr_ptr (r_rr_ptr),
      .i_fresh  (r_fresh),
      .o_grant  (w_grant)
   );

   msb u_msb (
      .i_x (r_operand),
      .o_y (w_msb)
   );

   ones u_ones (
      .i_x   (w_ones_in),
      .o_cnt (w_ones)
   );

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_ld_tmp     = 1'b0;
      w_ld_result  = 1'b0;
      w_rsp_done   = 1'b0;
      w_result_d   = '0;
      w_ones_in    = r_operand;
      w_req_rdy    = 2'b00;
      w_rsp_vld    = 2'b00;
      case (r_state)
         S_IDLE: begin
            w_req_rdy = reset ? w_grant : 2'b00;
            if (reset && (|w_grant)) begin
               w_accept     = 1'b1;
               w_next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            w_next_state = S_RESP;
            w_ld_result  = 1'b1;
            case (r_op)
               OP_ONES: w_result_d = zext_cnt(w_ones);
               OP_MSB:  w_result_d = w_msb;
               OP_LOG2: begin
                  w_ld_result  = 1'b0;
                  w_ld_tmp     = 1'b1;
                  w_next_state = S_EXEC2;
               end
               default: w_result_d = '0;
            endcase
         end
         S_EXEC2: begin
            // index of a one-hot word == popcount of the mask below it
            w_ones_in    = r_tmp - 16'd1;
            w_ld_result  = 1'b1;
            w_result_d   = (r_tmp == '0) ? LOG2_OF_ZERO : zext_cnt(w_ones);
            w_next_state = S_RESP;
         end
         S_RESP: begin
            w_rsp_vld[r_owner] = reset;
            if (reset && w_rsp_rdy[r_owner]) begin
               w_rsp_done   = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rr_ptr  <= 1'b0;
         r_fresh   <= 1'b1;
         r_owner   <= 1'b0;
         r_op      <= OP_ONES;
         r_operand <= '0;
         r_tmp     <= '0;
         r_result  <= '0;
      end else begin
         if (w_accept) begin
            r_owner   <= w_grant[1];
            r_op      <= w_grant[1] ? lane1.req_op   : lane0.req_op;
            r_operand <= w_grant[1] ? lane1.req_data : lane0.req_data;
         end
         if (w_ld_tmp)    r_tmp    <= w_msb;
         if (w_ld_result) r_result <= w_result_d;
         if (w_rsp_done) begin
            r_rr_ptr <= r_owner;
            r_fresh  <= 1'b0;
         end
      end
   end

   assign lane0.req_ready = w_req_rdy[0];
   assign lane1.req_ready = w_req_rdy[1];
   assign lane0.rsp_valid = w_rsp_vld[0];
   assign lane1.rsp_valid = w_rsp_vld[1];
   assign lane0.rsp_data  = w_rsp_vld[0] ? r_result : '0;
   assign lane1.rsp_data  = w_rsp_vld[1] ? r_result : '0;

endmodule
